// File: rtl/bench_event_gen.sv
// Benchmark event pulse generator: bursts of single-cycle pulses separated by gaps, with a stop count.
// Define BENCH_EVENT_LFSR_EN to mask the gap length with a 16-bit LFSR advanced once per burst end.
module bench_event_gen #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned GAP_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [GAP_W-1:0] burst_len,
  input  logic [GAP_W-1:0] gap_len,
  input  logic [CNT_W-1:0] max_events,
  output logic             benchmark_event,
  output logic [CNT_W-1:0] event_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             event_q, event_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [GAP_W-1:0] burst_q, burst_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [GAP_W-1:0] pulse_q, pulse_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [GAP_W-1:0] gap_eff;
  logic [CNT_W-1:0] cnt_inc;

`ifdef BENCH_EVENT_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] lfsr_nxt;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    event_d = 1'b0;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    gap_d   = gap_q;
    max_d   = max_q;
    pulse_d = pulse_q;
    gcnt_d  = gcnt_q;
`ifdef BENCH_EVENT_LFSR_EN
    lfsr_d   = lfsr_q;
    lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    gap_eff  = GAP_W'(lfsr_nxt) & gap_q;
`else
    gap_eff  = gap_q;
`endif
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        pulse_d = '0;
        gcnt_d  = '0;
`ifdef BENCH_EVENT_LFSR_EN
        lfsr_d  = LFSR_SEED;
`endif
        if (enable) begin
          burst_d = (burst_len == '0) ? GAP_W'(1) : burst_len;
          gap_d   = gap_len;
          max_d   = max_events;
          state_d = S_BURST;
          event_d = 1'b1;
          cnt_d   = CNT_W'(1);
          pulse_d = GAP_W'(1);
        end
      end

      S_BURST: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (event_q) begin
          // H half: stop if this pulse reached the programmed limit
          if ((max_q != '0) && (cnt_q == max_q)) begin
            state_d = S_DONE;
          end
        end else if (pulse_q < burst_q) begin
          event_d = 1'b1;
          cnt_d   = cnt_inc;
          pulse_d = pulse_q + GAP_W'(1);
        end else begin
          // Last L of the burst
`ifdef BENCH_EVENT_LFSR_EN
          lfsr_d = lfsr_nxt;
`endif
          if (gap_eff != '0) begin
            state_d = S_GAP;
            gcnt_d  = gap_eff;
            pulse_d = '0;
          end else begin
            event_d = 1'b1;
            cnt_d   = cnt_inc;
            pulse_d = GAP_W'(1);
          end
        end
      end

      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gcnt_q <= GAP_W'(1)) begin
          state_d = S_BURST;
          event_d = 1'b1;
          cnt_d   = cnt_inc;
          pulse_d = GAP_W'(1);
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q - GAP_W'(1);
        end
      end

      S_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_BURST) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      event_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      burst_q <= '0;
      gap_q   <= '0;
      max_q   <= '0;
      pulse_q <= '0;
      gcnt_q  <= '0;
`ifdef BENCH_EVENT_LFSR_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      event_q <= event_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      max_q   <= max_d;
      pulse_q <= pulse_d;
      gcnt_q  <= gcnt_d;
`ifdef BENCH_EVENT_LFSR_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign benchmark_event = event_q;
  assign event_cnt       = cnt_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: doc/bench_event_gen.md
# bench_event_gen

Synthesizable benchmark-event producer that sits inside the RTL top and drives the `benchmark_event` line which the simulation harness counts on rising edges. It emits bursts of single-cycle pulses separated by idle gaps, keeps its own event count, and stops after a programmable number of events. Because the harness counts edges and this block counts pulses, the two tallies can be cross-checked at end of simulation.

## Interface
- `CNT_W`, 32, width of event counter and `max_events`
- `GAP_W`, 8, width of `burst_len` and `gap_len`
- `LFSR_SEED`, 16'hACE1, non-zero reset value of the gap LFSR; only used when `BENCH_EVENT_LFSR_EN` is defined

Ports:
- `i_clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high reset
- `enable` in 1: level; high starts and sustains generation, low returns to IDLE
- `burst_len` in GAP_W: pulses per burst; 0 is treated as 1
- `gap_len` in GAP_W: low cycles between bursts (fixed mode) or gap mask (LFSR mode)
- `max_events` in CNT_W: stop after this many pulses; 0 means free-running
- `benchmark_event` out 1: registered event pulse, exactly one cycle high, always followed by at least one low cycle
- `event_cnt` out CNT_W: pulses emitted since leaving IDLE; updates in the same cycle as the pulse
- `busy` out 1: high in BURST or GAP
- `done` out 1: high in DONE

## Operation
- States: IDLE, BURST, GAP, DONE. All outputs are registered.
- Reset: state=IDLE, `benchmark_event`=0, `event_cnt`=0, `busy`=0, `done`=0, burst/gap counters=0, LFSR=`LFSR_SEED`.
- IDLE: `event_cnt` cleared to 0. When `enable`=1, latch `burst_len` (0 becomes 1), `gap_len` and `max_events`, then go to BURST. Input changes after the latch have no effect until the next IDLE.
- BURST: alternate H,L per cycle, starting with H, for b pulses (2b cycles). Each H increments `event_cnt`.
- After the last L of a burst: go to GAP if the effective gap g>0, otherwise go straight to BURST.
- GAP: `benchmark_event` is held low for g cycles, then the block returns to BURST.
- Stop condition: when `max_events`≠0 and a pulse makes `event_cnt`==`max_events`, the next cycle is DONE. The L half of that pulse is the DONE cycle, and any remaining burst pulses and gap are abandoned.
- DONE: `done`=1, `benchmark_event`=0, `event_cnt` held. The block stays in DONE while `enable`=1. When `enable`=0, it goes to IDLE.
- `enable`=0 in BURST or GAP: next state is IDLE. A pulse already high completes its single cycle, and no new pulse starts. `event_cnt` clears in IDLE.
- Free-running (`max_events`=0): `event_cnt` saturates at all-ones while pulses continue.
- `reset` overrides everything in any state, including mid-pulse: output is 0 the next cycle.

## Timing
- `enable` sampled high in IDLE at cycle N: first pulse at N+1, `busy`=1 from N+1.
- Pulse period within a burst: 2 cycles. Burst-to-burst period: 2b+g cycles.
- `done` rises the cycle after the final pulse. `busy` falls in the same cycle.
- `enable` low at cycle M: state=IDLE and `busy`=0 at M+1; `event_cnt`=0 at M+2.

## Configuration
- `BENCH_EVENT_LFSR_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per burst end.
  - g = LFSR[GAP_W-1:0] & latched `gap_len`, sampled after advancing.
  - Reset and IDLE reload `LFSR_SEED`, so the gap sequence is repeatable.
- Undefined: g = latched `gap_len`. No LFSR logic is present and `LFSR_SEED` is ignored.

## Test plan
- Fixed gap, b=3, g=4, max=6, `enable` rises at cycle 0 -> pulses at cycles 1,3,5,11,13,15; `event_cnt`=6 at 15; `done`=1 from 16; `busy`=0 at 16.
- b=0, g=0, max=4 -> treated as b=1, so pulses at 1,3,5,7 with continuous H/L; `done` at 8.
- max=0, b=2, g=1 -> runs indefinitely with period 5; forcing `event_cnt` to all-ones shows it holds at all-ones.
- `enable` dropped at cycle 4 of the first case -> no pulse after 3, IDLE at 5, `event_cnt`=0 at 6; re-enable restarts from count 0.
- `reset` asserted while `benchmark_event`=1 -> all outputs at reset values next cycle, IDLE.
- With `BENCH_EVENT_LFSR_EN`, gap_len=8'hFF, b=1 -> gaps match a reference LFSR model from `LFSR_SEED`; two runs produce identical pulse timing.
